shift_seq_arbiter: RTL and testbench
====================================

Name: shift_seq_arbiter

Overview:
- Shared, multi-cycle shift unit serving two requesters through valid/ready handshakes.
- Round-robin arbiter picks one request; an FSM then applies the log-shifter stages (1, 2, 4, 8, 16) one per clock to a registered accumulator.
- Supports SLL, SRL and SRA. Used where a full single-cycle barrel shifter per client is too costly (e.g. shared between CSR/LSU-align paths).

Parameters:
DW  32  operand width; fixed at 32, shift amount is 5 bits

Ports:
clk         in   1   clock, all state on rising edge
rst         in   1   synchronous, active-high reset
req0_valid  in   1   requester 0 has a request
req0_ready  out  1   requester 0 request accepted this cycle (combinational)
req0_data   in   32  operand
req0_shamt  in   5   shift amount
req0_op     in   2   00 SLL, 01 SRL, 11 SRA, 10 pass-through
req1_valid / req1_ready / req1_data / req1_shamt / req1_op  same as requester 0
rsp_valid   out  1   result available
rsp_ready   in   1   consumer takes result
rsp_data    out  32  shifted result (registered)
rsp_id      out  1   requester that owns the result
busy        out  1   high whenever state != IDLE

Behaviour:
- States: IDLE, SHIFT, RESP. Reset: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, stage counter 0, last_grant 1 (req0 wins first contest).
- reqN_ready forced 0 while rst is high.
- IDLE arbitration:
  - reqN_ready = (state==IDLE) & grantN.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
- Handshake cycle C (valid & ready):
  - Capture data into acc, plus shamt, op and id.
  - Update last_grant.
  - Go to SHIFT with stage k=0.
- SHIFT: on each edge, if shamt[k] then update acc by 2^k, else hold acc. Fill rules:
  - SLL: left shift, zero fill.
  - SRL: right shift, zero fill.
  - SRA: right shift, fill with acc[31]. Sign is invariant across stages.
  - op 10: acc unchanged.
- After stage k=4: rsp_data <= acc result, rsp_valid <= 1, go to RESP.
- Latency: SHIFT occupies cycles C+1..C+5; rsp_valid high from C+6 regardless of shamt.
- RESP: rsp_valid, rsp_data and rsp_id held stable until rsp_ready.
  - On the handshake edge: rsp_valid <= 0, go to IDLE.
  - Next accept is possible no earlier than the cycle after the response handshake. No overlap, so throughput is 1 op per ≥7 cycles.
- Requests are never accepted outside IDLE. A requester that drops valid before ready is simply not served. A request is never half-captured.
- rsp_ready is ignored outside RESP.
- Reset mid-operation (SHIFT or RESP): transaction discarded, no response produced, state returns to IDLE, last_grant 1.
- rsp_data is stable from rsp_valid rise until handshake. After handshake it keeps its last value until the next result.

Optional Feature:
SHIFT_SKIP_EN
- Defined: early termination. Let m = index of the highest set bit of shamt.
  - shamt==0: handshake edge goes IDLE→RESP directly with rsp_data = operand; rsp_valid from C+1.
  - Otherwise SHIFT runs stages 0..m, including no-op stages below m; RESP after stage m; rsp_valid from C+2+m.
  - op 10: treated as shamt 0.
- Undefined: fixed 5-stage latency as above. No shamt-dependent timing.

Test Plan:
1. After reset, req0 SRA data 0x8000_0000 shamt 4, rsp_ready=1 -> rsp_valid at C+6, rsp_data 0xF800_0000, rsp_id 0, busy high C+1..C+6.
2. req1 SLL 0x0000_0001 shamt 31 -> 0x8000_0000; then req1 SRL 0xFFFF_FFFF shamt 31 -> 0x0000_0001; SRA 0x7FFF_FFFF shamt 31 -> 0x0000_0000.
3. req0 and req1 valid together and held -> req0 served first (rsp_id 0), then req1 (rsp_id 1), then req0 again: strict alternation.
4. rsp_ready low for 3 cycles in RESP -> rsp_valid/rsp_data/rsp_id constant, req0_ready/req1_ready 0; handshake then IDLE next cycle.
5. rst asserted for 1 cycle during SHIFT stage 2 -> no rsp_valid ever for that request, busy 0 next cycle; a new req1 request is accepted and req0 has priority on a tie.
6. op 10, data 0x1234_5678 shamt 7 -> rsp_data 0x1234_5678. With SHIFT_SKIP_EN: shamt 0 -> rsp_valid at C+1; shamt 3 -> at C+3; shamt 16 -> at C+6.

Source files
------------

// File: rtl/shift_seq_arbiter.sv
// Shared multi-cycle shift unit: two round-robin requesters, one log-shifter stage per clock.
// Build option SHIFT_SKIP_EN: stop after the highest set shamt bit (shamt 0 / pass-through go straight to RESP).
module shift_seq_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic [4:0]    req0_shamt,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  input  logic [4:0]    req1_shamt,
  input  logic [1:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id,
  output logic          busy
);

  // state | meaning
  // IDLE  | arbitrating, ready may be offered to one requester
  // SHIFT | applying stage 'stage' (shift by 2^stage) to acc
  // RESP  | result presented, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t        state, state_next;
  logic [DW-1:0] acc, acc_step;
  logic [4:0]    shamt_r;
  logic [1:0]    op_r;
  logic          id_r;
  logic [2:0]    stage;
  logic          last_grant;
  logic          grant0, grant1, accept;
  logic [DW-1:0] sel_data;
  logic [4:0]    sel_shamt;
  logic [1:0]    sel_op;
  logic [4:0]    step_amt;
  logic          direct;
  logic [2:0]    last_stage;

`ifdef SHIFT_SKIP_EN
  function automatic logic [2:0] top_bit(input logic [4:0] s);
    top_bit = 3'd0;
    for (int i = 0; i < 5; i++)
      if (s[i]) top_bit = 3'(i);
  endfunction

  assign direct     = (sel_shamt == 5'd0) || (sel_op == 2'b10);
  assign last_stage = top_bit(shamt_r);
`else
  assign direct     = 1'b0;
  assign last_stage = 3'd4;
`endif

  // On a tie the requester that did not win last time is granted.
  assign grant0     = req0_valid && (!req1_valid || last_grant);
  assign grant1     = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = !rst && (state == IDLE) && grant0;
  assign req1_ready = !rst && (state == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  assign sel_data  = req1_ready ? req1_data  : req0_data;
  assign sel_shamt = req1_ready ? req1_shamt : req0_shamt;
  assign sel_op    = req1_ready ? req1_op    : req0_op;

  always_comb begin
    acc_step = acc;
    step_amt = 5'd1 << stage;
    if (shamt_r[stage]) begin
      case (op_r)
        2'b00:   acc_step = acc << step_amt;
        2'b01:   acc_step = acc >> step_amt;
        2'b11:   acc_step = $unsigned($signed(acc) >>> step_amt);
        default: acc_step = acc;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = direct ? RESP : SHIFT;
      SHIFT:   if (stage == last_stage) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      shamt_r    <= '0;
      op_r       <= '0;
      id_r       <= 1'b0;
      stage      <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= sel_data;
            shamt_r    <= sel_shamt;
            op_r       <= sel_op;
            id_r       <= req1_ready;
            last_grant <= req1_ready;
            stage      <= 3'd0;
            if (direct) begin
              rsp_valid <= 1'b1;
              rsp_data  <= sel_data;
              rsp_id    <= req1_ready;
            end
          end
        end
        SHIFT: begin
          acc   <= acc_step;
          stage <= stage + 3'd1;
          if (stage == last_stage) begin
            rsp_valid <= 1'b1;
            rsp_data  <= acc_step;
            rsp_id    <= id_r;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Scoreboard bench for shift_seq_arbiter; expected results come from a plain-arithmetic model.
// Honors SHIFT_SKIP_EN for the expected response latency.
module tb_shift_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  shift_seq_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          lg_m = 1'b1;
  bit          resp_m = 1'b0;
  bit          prev_v = 1'b0;
  logic [31:0] prev_d;
  bit          prev_id;
  bit          rnd_rdy = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(input bit ok, input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b11:   return sd >>> s;
      default: return d;
    endcase
  endfunction

`ifdef SHIFT_SKIP_EN
  function automatic int skip_lat(input logic [4:0] s, input logic [1:0] o);
    int m;
    m = 0;
    if (s == 5'd0 || o == 2'b10) return 1;
    for (int i = 0; i < 5; i++) if (s[i]) m = i;
    return 2 + m;
  endfunction
`endif

  // Monitor: arbitration model, scoreboard push on accept, pop/compare on response.
  always @(negedge clk) begin
    logic [1:0]  rv, ev;
    bit          busy_exp;
    exp_t        e;
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    if (rst) begin
      chk({req1_ready, req0_ready} == 2'b00, "ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
      sb.delete();
      lg_m   = 1'b1;
      resp_m = 1'b0;
      prev_v = 1'b0;
    end else begin
      busy_exp = (sb.size() != 0) || resp_m;
      chk(busy == busy_exp, "busy", {31'd0, busy}, {31'd0, busy_exp});
      if (rsp_valid && !prev_v) begin
        chk(sb.size() != 0, "spurious_rsp", rsp_data, 32'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
          chk(rsp_id == e.id, "rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk(cyc == e.due, "rsp_latency", cyc, e.due);
          resp_m = 1'b1;
        end
      end else if (rsp_valid && prev_v) begin
        chk(rsp_data == prev_d, "hold_data", rsp_data, prev_d);
        chk(rsp_id == prev_id, "hold_id", {31'd0, rsp_id}, {31'd0, prev_id});
      end
      if (!rsp_valid && sb.size() != 0 && cyc > sb[0].due) begin
        chk(rsp_valid, "rsp_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (rsp_valid && rsp_ready) resp_m = 1'b0;

      ev = 2'b00;
      if (!busy_exp) begin
        if (req0_valid && req1_valid) ev = lg_m ? 2'b01 : 2'b10;
        else ev = {req1_valid, req0_valid};
      end
      rv = {req1_ready, req0_ready};
      chk(rv == ev, "ready_grant", {30'd0, rv}, {30'd0, ev});
      if (ev != 2'b00) begin
        e.id = ev[1];
        d = ev[1] ? req1_data : req0_data;
        s = ev[1] ? req1_shamt : req0_shamt;
        o = ev[1] ? req1_op : req0_op;
        e.data = ref_shift(d, s, o);
`ifdef SHIFT_SKIP_EN
        e.due = cyc + skip_lat(s, o);
`else
        e.due = cyc + 6;
`endif
        sb.push_back(e);
        lg_m = ev[1];
      end
      prev_v  = rsp_valid;
      prev_d  = rsp_data;
      prev_id = rsp_id;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input bit who, input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    bit got;
    got = 1'b0;
    if (!who) begin
      req0_data = d; req0_shamt = s; req0_op = o; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_shamt = s; req1_op = o; req1_valid = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if ((!who && req0_ready) || (who && req1_ready)) got = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!who) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    chk(got, "accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && !(sb.size() == 0 && !resp_m); i++) @(negedge clk);
    chk(sb.size() == 0 && !resp_m, "drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Both requesters held valid; expect n grants alternating, starting with first_id.
  task automatic tie(input int n, input bit first_id);
    int k;
    logic [1:0] exp_rv;
    k = 0;
    req0_data = 32'h0F0F_00FF; req0_shamt = 5'd3; req0_op = 2'b01;
    req1_data = 32'hC000_0001; req1_shamt = 5'd1; req1_op = 2'b11;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 300 && k < n; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        exp_rv = (first_id ^ k[0]) ? 2'b10 : 2'b01;
        chk({req1_ready, req0_ready} == exp_rv, "tie_order",
            {30'd0, req1_ready, req0_ready}, {30'd0, exp_rv});
        k++;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk(k == n, "tie_timeout", k, n);
  endtask

  initial begin
    bit got;
    logic [1:0] mask;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req0_shamt = '0; req0_op = '0;
    req1_data = '0; req1_shamt = '0; req1_op = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(rsp_valid == 1'b0, "rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk(rsp_data == 32'd0, "rst_rsp_data", rsp_data, 32'd0);
    chk(rsp_id == 1'b0, "rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    send(1'b0, 32'h8000_0000, 5'd4, 2'b11);
    wait_idle();

    send(1'b1, 32'h0000_0001, 5'd31, 2'b00);
    send(1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01);
    send(1'b1, 32'h7FFF_FFFF, 5'd31, 2'b11);
    wait_idle();

    tie(3, 1'b0);
    wait_idle();

    // Stall the consumer for three cycles while req1 waits.
    rsp_ready = 1'b0;
    send(1'b0, 32'hA5A5_0F0F, 5'd8, 2'b01);
    req1_data = 32'h1357_9BDF; req1_shamt = 5'd2; req1_op = 2'b00; req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    chk(got, "stall_rsp_timeout", {31'd0, got}, 32'd1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req1_ready;
    end
    @(posedge clk);
    #1 req1_valid = 1'b0;
    chk(got, "stall_accept_timeout", {31'd0, got}, 32'd1);
    wait_idle();

    // Reset during SHIFT stage 2: request is discarded.
    send(1'b0, 32'hDEAD_BEEF, 5'd9, 2'b00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tie(2, 1'b0);
    wait_idle();
    send(1'b1, 32'h0000_F00D, 5'd5, 2'b00);
    wait_idle();

    send(1'b0, 32'h1234_5678, 5'd7, 2'b10);
    send(1'b1, 32'h8765_4321, 5'd0, 2'b00);
    send(1'b0, 32'h8765_4321, 5'd3, 2'b11);
    send(1'b1, 32'h8765_4321, 5'd16, 2'b01);
    wait_idle();

    rnd_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      req0_data = $urandom; req0_shamt = 5'($urandom); req0_op = 2'($urandom);
      req1_data = $urandom; req1_shamt = 5'($urandom); req1_op = 2'($urandom);
      req0_valid = mask[0];
      req1_valid = mask[1];
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        got = req0_ready || req1_ready;
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk(got, "rand_accept_timeout", {31'd0, got}, 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
